mpfifo_flow_ctrl: RTL

//   Flow controller that sequences a SyncMultiPortFIFO between a multi-slot producer (fetch) and a

---
 rtl/mpfifo_flow_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/mpfifo_flow_ctrl.sv
// mpfifo_flow_ctrl: flow controller between a multi-slot producer, a SyncMultiPortFIFO and a multi-slot consumer
// Ports: clk/rst (sync active-high); flush_i; producer prod_valid_i/prod_num_i/prod_ready_o;
//   FIFO side fifo_flush_o, fifo_write_valid_o/fifo_write_num_o/fifo_write_ready_i, fifo_read_ready_o/fifo_read_num_o;
//   consumer cons_ready_num_i/cons_valid_o; status count_o, busy_flush_o; perf_full_stall_o, perf_empty_o.
// Define MPFIFO_FLOW_CTRL_PERF_EN to enable the perf counters (otherwise tied to 0); define DEBUG for input-range assertions.
module mpfifo_flow_ctrl #(
  parameter int FIFO_DEPTH   = 16,
  parameter int WPORTS_NUM   = 4,
  parameter int RPORTS_NUM   = 4,
  parameter int FLUSH_BUBBLE = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  input  logic                              prod_valid_i,
  input  logic [$clog2(WPORTS_NUM+1)-1:0]   prod_num_i,
  output logic                              prod_ready_o,
  output logic                              fifo_flush_o,
  output logic                              fifo_write_valid_o,
  output logic [$clog2(WPORTS_NUM+1)-1:0]   fifo_write_num_o,
  input  logic                              fifo_write_ready_i,
  input  logic [$clog2(RPORTS_NUM+1)-1:0]   cons_ready_num_i,
  output logic                              fifo_read_ready_o,
  output logic [$clog2(RPORTS_NUM+1)-1:0]   fifo_read_num_o,
  output logic [RPORTS_NUM-1:0]             cons_valid_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic                              busy_flush_o,
  output logic [31:0]                       perf_full_stall_o,
  output logic [31:0]                       perf_empty_o
);
  localparam int WN = $clog2(WPORTS_NUM+1);
  localparam int RN = $clog2(RPORTS_NUM+1);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [3:0] RELOAD = 4'(FLUSH_BUBBLE-1);
  typedef enum logic {FLUSH, RUN} state_t;
  state_t state, state_next;
  logic [3:0] bubble, bubble_next;
  logic [CW-1:0] count, free;
  logic [WN-1:0] pn;
  logic [RN-1:0] cr, rd_lim, rd_num;
  logic run, wr_fire;
  assign run = (state == RUN) & ~rst;
  // out-of-range slot counts are clamped so the FIFO only ever sees legal numbers
  assign pn = (prod_num_i > WN'(WPORTS_NUM)) ? WN'(WPORTS_NUM) : prod_num_i;
  assign cr = (cons_ready_num_i > RN'(RPORTS_NUM)) ? RN'(RPORTS_NUM) : cons_ready_num_i;
  assign free = CW'(FIFO_DEPTH) - count;
  // only a full-width slot of free space accepts a push, so a push never needs splitting
  assign prod_ready_o = run & ~flush_i & fifo_write_ready_i & (free >= CW'(WPORTS_NUM));
  assign wr_fire = prod_valid_i & prod_ready_o & (pn != '0);
  assign fifo_write_valid_o = wr_fire;
  assign fifo_write_num_o = wr_fire ? pn : '0;
  // pop sizing uses the registered count only, honouring the FIFO's one-cycle write latency
  assign rd_lim = (count < CW'(RPORTS_NUM)) ? RN'(count) : RN'(RPORTS_NUM);
  assign rd_num = (cr < rd_lim) ? cr : rd_lim;
  assign fifo_read_ready_o = run & ~flush_i & (rd_num != '0);
  assign fifo_read_num_o = fifo_read_ready_o ? rd_num : '0;
  assign fifo_flush_o = rst | flush_i | (state == FLUSH);
  assign busy_flush_o = state == FLUSH;
  assign count_o = count;
  always_comb begin
    for (int k = 0; k < RPORTS_NUM; k++)
      cons_valid_o[k] = fifo_read_num_o > RN'(k);
  end
  always_comb begin
    state_next = state;
    bubble_next = bubble;
    if (flush_i) begin
      state_next = FLUSH;
      bubble_next = RELOAD;
    end else if (state == FLUSH) begin
      state_next = (bubble == '0) ? RUN : FLUSH;
      bubble_next = (bubble == '0) ? bubble : bubble - 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FLUSH;
      bubble <= RELOAD;
      count <= '0;
    end else begin
      state <= state_next;
      bubble <= bubble_next;
      count <= flush_i ? '0 : count + CW'(fifo_write_num_o) - CW'(fifo_read_num_o);
    end
  end
`ifdef MPFIFO_FLOW_CTRL_PERF_EN
  logic [31:0] full_stall, empty_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      full_stall <= '0;
      empty_cnt <= '0;
    end else begin
      if (run & prod_valid_i & ~prod_ready_o & (full_stall != '1))
        full_stall <= full_stall + 32'd1;
      if (run & (count == '0) & (cons_ready_num_i != '0) & (empty_cnt != '1))
        empty_cnt <= empty_cnt + 32'd1;
    end
  end
  assign perf_full_stall_o = full_stall;
  assign perf_empty_o = empty_cnt;
`else
  assign perf_full_stall_o = '0;
  assign perf_empty_o = '0;
`endif
`ifdef DEBUG
  always_ff @(posedge clk) begin
    if (!rst)
      assert ((prod_num_i <= WN'(WPORTS_NUM)) && (cons_ready_num_i <= RN'(RPORTS_NUM)))
        else $error("illegal slot count prod_num_i=%0d cons_ready_num_i=%0d", prod_num_i, cons_ready_num_i);
  end
`endif
endmodule
